// File: rtl/implication_queue.sv
// -----------------------------------------------------------------------------
// implication_queue
//
// Buffers unit-clause implications between the clause evaluator and the
// assignment writer of a SAT solver.  Implications are stored in a circular
// FIFO.  A per-variable pending table remembers which variables are queued
// and with which polarity, so that:
//   - a repeat implication with the same polarity is dropped silently,
//   - a repeat implication with the opposite polarity raises a sticky
//     conflict, which freezes both sides until a flush (backtrack).
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   flush         backtrack: empties queue, clears pending table and conflict
//   in_valid      implication offered
//   in_variable   implied variable index
//   in_value      implied polarity
//   in_ready      implication accepted this cycle when in_valid is high
//   out_valid     head entry available
//   out_variable  head variable index
//   out_value     head polarity
//   out_ready     writer consumes the head this cycle
//   conflict      sticky conflict flag
//   count         current occupancy (0..QUEUE_DEPTH)
//   drop_count    (only with IMPL_QUEUE_STATS_EN) saturating count of
//                 same-polarity drops, cleared by reset and flush
//
// Build option
//   IMPL_QUEUE_STATS_EN  when defined, adds the drop_count output and counter.
// -----------------------------------------------------------------------------
module implication_queue #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1,
    parameter int QUEUE_DEPTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [VARIABLE_INDEX:0]       in_variable,
    input  logic                          in_value,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [VARIABLE_INDEX:0]       out_variable,
    output logic                          out_value,
    input  logic                          out_ready,
    output logic                          conflict,
    output logic [$clog2(QUEUE_DEPTH):0]  count
`ifdef IMPL_QUEUE_STATS_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    localparam logic [0:0] STATE_RUN      = 1'b0;
    localparam logic [0:0] STATE_CONFLICT = 1'b1;

    logic [0:0]              state;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [NUM_VARIABLE-1:0] pending;
    logic [NUM_VARIABLE-1:0] pending_value;

    logic [VARIABLE_INDEX:0] fifo_variable [QUEUE_DEPTH];
    logic                    fifo_value    [QUEUE_DEPTH];

    logic             full;
    logic             empty;
    logic             accept;
    logic             dequeue;
    logic             hit;
    logic             same;
    logic             drop;
    logic             clash;
    logic             enqueue;
    logic [CNT_W-1:0] count_next;

    assign conflict = (state == STATE_CONFLICT);

    // Handshake decode and classification of the offered implication.
    // The pending lookup uses the pre-edge table, so a variable leaving
    // the head in this very cycle still counts as pending.
    always_comb begin
        full         = (count == FULL_COUNT);
        empty        = (count == CNT_ZERO);
        in_ready     = ~full & ~conflict & ~flush;
        out_valid    = ~empty & ~conflict;
        accept       = in_valid & in_ready;
        // flush overrides any consume offered in the same cycle
        dequeue      = out_valid & out_ready & ~flush;
        hit          = pending[in_variable];
        same         = (pending_value[in_variable] == in_value);
        drop         = accept & hit & same;
        clash        = accept & hit & ~same;
        enqueue      = accept & ~hit;
        out_variable = fifo_variable[head];
        out_value    = fifo_value[head];
        case ({enqueue, dequeue})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Control state, pointers, occupancy and the pending table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= STATE_RUN;
            head          <= PTR_ZERO;
            tail          <= PTR_ZERO;
            count         <= CNT_ZERO;
            pending       <= {NUM_VARIABLE{1'b0}};
            pending_value <= {NUM_VARIABLE{1'b0}};
        end else if (flush) begin
            state         <= STATE_RUN;
            head          <= PTR_ZERO;
            tail          <= PTR_ZERO;
            count         <= CNT_ZERO;
            pending       <= {NUM_VARIABLE{1'b0}};
            pending_value <= {NUM_VARIABLE{1'b0}};
        end else begin
            case (state)
                STATE_RUN: begin
                    if (clash) begin
                        state <= STATE_CONFLICT;
                    end
                end
                STATE_CONFLICT: state <= STATE_CONFLICT;
                default:        state <= STATE_RUN;
            endcase
            count <= count_next;
            if (dequeue) begin
                head                          <= head + PTR_ONE;
                pending[fifo_variable[head]]  <= 1'b0;
            end
            // An enqueued variable is never the one being dequeued (it
            // would have been pending), so set and clear never collide.
            if (enqueue) begin
                tail                       <= tail + PTR_ONE;
                pending[in_variable]       <= 1'b1;
                pending_value[in_variable] <= in_value;
            end
        end
    end

    // FIFO storage; contents are meaningless while the slot is not occupied.
    always_ff @(posedge clock) begin
        if (enqueue) begin
            fifo_variable[tail] <= in_variable;
            fifo_value[tail]    <= in_value;
        end
    end

`ifdef IMPL_QUEUE_STATS_EN
    // Saturating count of same-polarity duplicate drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= 16'h0000;
        end else if (flush) begin
            drop_count <= 16'h0000;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'h0001;
        end
    end
`else
    // Without the statistics counter a duplicate is simply discarded.
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_implication_queue.sv
module tb_implication_queue;

    localparam int NV    = 128;
    localparam int VI    = 6;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [VI:0] in_variable = '0;
    logic        in_value = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [VI:0] out_variable;
    logic        out_value;
    logic        out_ready = 1'b0;
    logic        conflict;
    logic [3:0]  count;
`ifdef IMPL_QUEUE_STATS_EN
    logic [15:0] drop_count;
`endif

    implication_queue #(.NUM_VARIABLE(NV), .QUEUE_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_variable(in_variable), .in_value(in_value),
        .in_ready(in_ready), .out_valid(out_valid), .out_variable(out_variable),
        .out_value(out_value), .out_ready(out_ready), .conflict(conflict),
        .count(count)
`ifdef IMPL_QUEUE_STATS_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The queue content itself is the pending table: a variable is pending
    // exactly when some queued entry carries it.
    int m_var[$];
    bit m_val[$];
    bit m_conf  = 1'b0;
    int m_drops = 0;

    task automatic model_clear();
        m_var.delete();
        m_val.delete();
        m_conf  = 1'b0;
        m_drops = 0;
    endtask

    // Drive one cycle, compare outputs against the model, clock, update model.
    task automatic step(input bit fl, input bit iv, input int vr, input bit vl, input bit ordy);
        bit e_ir, e_ov, acc, pop, hit, same;
        @(negedge clock);
        flush = fl; in_valid = iv; in_variable = vr[VI:0]; in_value = vl; out_ready = ordy;
        #1;
        e_ir = (m_var.size() != DEPTH) && !m_conf && !fl;
        e_ov = (m_var.size() != 0) && !m_conf;
        chk("in_ready", int'(in_ready), int'(e_ir));
        chk("out_valid", int'(out_valid), int'(e_ov));
        chk("count", int'(count), m_var.size());
        chk("conflict", int'(conflict), int'(m_conf));
        if (e_ov) begin
            chk("out_variable", int'(out_variable), m_var[0]);
            chk("out_value", int'(out_value), int'(m_val[0]));
        end
`ifdef IMPL_QUEUE_STATS_EN
        chk("drop_count", int'(drop_count), m_drops);
`endif
        @(posedge clock);
        if (fl) begin
            model_clear();
        end else begin
            acc = iv && e_ir;
            pop = e_ov && ordy;
            hit = 1'b0; same = 1'b0;
            foreach (m_var[i]) if (m_var[i] == vr) begin hit = 1'b1; same = (m_val[i] == vl); end
            if (acc && hit && same && m_drops < 65535) m_drops++;
            if (acc && hit && !same) m_conf = 1'b1;
            if (pop) begin void'(m_var.pop_front()); void'(m_val.pop_front()); end
            if (acc && !hit) begin m_var.push_back(vr); m_val.push_back(vl); end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit fl; bit iv; int vr; bit vl; bit ordy;
        bit e_ir; bit e_ov; int e_var; bit e_val; int e_cnt; bit e_cf; bit chk_out; int e_drop;
    } vec_t;

    vec_t tbl[14];

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        //           fl iv vr vl rdy  ir ov var val cnt cf chk drop
        tbl[0]  = '{0, 1, 5, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1,   1, 1, 5, 1, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 3, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 3, 0, 0,   1, 1, 3, 0, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,   1, 1, 3, 0, 1, 0, 1, 1};
        tbl[6]  = '{0, 1, 7, 1, 0,   1, 1, 3, 0, 1, 0, 1, 1};
        tbl[7]  = '{0, 1, 7, 0, 0,   1, 1, 3, 0, 2, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0, 1};
        tbl[9]  = '{1, 1, 9, 1, 1,   0, 0, 0, 0, 2, 1, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 7, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1,   1, 1, 7, 0, 1, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};

        // reset state, sampled while reset is held
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_conflict", int'(conflict), 0);
        reset = 1'b0;

        // table-driven directed vectors
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            flush = tbl[i].fl; in_valid = tbl[i].iv; in_variable = tbl[i].vr[VI:0];
            in_value = tbl[i].vl; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("v%0d_conflict", i), int'(conflict), int'(tbl[i].e_cf));
            if (tbl[i].chk_out) begin
                chk($sformatf("v%0d_out_variable", i), int'(out_variable), tbl[i].e_var);
                chk($sformatf("v%0d_out_value", i), int'(out_value), int'(tbl[i].e_val));
            end
`ifdef IMPL_QUEUE_STATS_EN
            chk($sformatf("v%0d_drop_count", i), int'(drop_count), tbl[i].e_drop);
`endif
        end

        // fill to capacity, blocked push with pop, then wrap-around traffic
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, i, i[0], 0);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("full_count", int'(count), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        step(0, 1, 20, 1, 1);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("after_pop_count", int'(count), DEPTH - 1);
        chk("after_pop_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 20; i++) step(0, 1, 30 + i, i[0], 1);

        // asynchronous reset in mid-cycle with four entries queued
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 40 + i, 1, 0);
        @(negedge clock);
        in_valid = 1'b0; #1;
        chk("pre_async_count", int'(count), 4);
        #1 reset = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_out_valid", int'(out_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        step(0, 1, 40, 0, 0);
        step(0, 0, 0, 0, 0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit fl;
            fl = m_conf ? ($urandom_range(3) == 0) : ($urandom_range(60) == 0);
            step(fl, $urandom_range(9) < 7, $urandom_range(11), $urandom_range(1) == 1,
                 $urandom_range(1) == 1);
        end
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
